// File: rtl/pipeline_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_pkg                                                     |
// | Shared types and constants for the 5-stage RV64 pipeline control. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0           = 5'd0;
  localparam int         LOAD_LAT_DEFAULT = 1;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_flush_ctrl_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter                                                      |
// | W-bit incrementer that holds at all-ones; synchronous reset.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == {W{1'b1}});
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_flush_ctrl                                                |
// | Load-use stall / taken-branch flush control for IF/ID, ID/EX and |
// | EX/MEM. Optional perf counters under HAZARD_PERF_CNT_EN.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hazard_flush_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] C_SCNT_LOAD = 3'(LOAD_LAT - 1);
  localparam bit         C_MULTI     = (LOAD_LAT > 1);

  state_t     r_state;
  state_t     w_state_next;
  state_t     w_state_eff;
  logic [2:0] r_scnt;
  logic [2:0] w_scnt_next;
  logic       w_hz;

  assign w_hz = id_ex_memread && (id_ex_rd != REG_X0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  // Outputs during reset must look like RUN regardless of the held state.
  assign w_state_eff = reset ? RUN : r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_scnt  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_scnt  <= w_scnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_scnt_next  = r_scnt;
    if (branch_taken) begin
      w_state_next = FLUSH;
      w_scnt_next  = 3'd0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_hz && C_MULTI) begin
            w_state_next = STALL;
            w_scnt_next  = C_SCNT_LOAD;
          end
        end
        STALL: begin
          w_scnt_next = r_scnt - 3'd1;
          if (r_scnt == 3'd1) begin
            w_state_next = RUN;
          end
        end
        FLUSH: begin
          w_state_next = RUN;
        end
        default: begin
          w_state_next = RUN;
          w_scnt_next  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if ((w_state_eff == RUN && w_hz) || (w_state_eff == STALL)) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_stall_inc;
  assign w_stall_inc = !pc_write && !branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_taken),
    .count (flush_count)
  );
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule : hazard_flush_ctrl
`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_flush_ctrl                                             |
// | Table-driven and hand-sequenced checks of hazard_flush_ctrl.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       mr, br;

  logic        pw1, iw1, iff1, ief1, emf1;
  logic [15:0] sc1, fc1;
  logic        pw3, iw3, iff3, ief3, emf3;
  logic [15:0] sc3, fc3;
  logic        pw4, iw4, iff4, ief4, emf4;
  logic [3:0]  sc4, fc4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(mr), .branch_taken(br), .pc_write(pw1), .if_id_write(iw1),
    .if_id_flush(iff1), .id_ex_flush(ief1), .ex_mem_flush(emf1),
    .stall_count(sc1), .flush_count(fc1));

  hazard_flush_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(mr), .branch_taken(br), .pc_write(pw3), .if_id_write(iw3),
    .if_id_flush(iff3), .id_ex_flush(ief3), .ex_mem_flush(emf3),
    .stall_count(sc3), .flush_count(fc3));

  hazard_flush_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .if_id_rs1(rs1), .if_id_rs2(rs2), .id_ex_rd(rd),
    .id_ex_memread(mr), .branch_taken(br), .pc_write(pw4), .if_id_write(iw4),
    .if_id_flush(iff4), .id_ex_flush(ief4), .ex_mem_flush(emf4),
    .stall_count(sc4), .flush_count(fc4));

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] STL = 5'b00010;
  localparam logic [4:0] BRF = 5'b11111;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br;
    logic [4:0] exp_o;
    int         exp_s, exp_f;
  } vec_t;

  vec_t vecs[15];

  function automatic int cexp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic m, input logic t);
    reset = r; rs1 = a; rs2 = b; rd = d; mr = m; br = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // LOAD_LAT=3 sequence: load-use, rd=x0, branch in STALL, hz in FLUSH, reset mid-stall
    vecs[0]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 0, 0};
    vecs[1]  = '{1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, DEF, 0, 0};
    vecs[2]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, STL, 0, 0};
    vecs[3]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, STL, 1, 0};
    vecs[4]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, STL, 2, 0};
    vecs[5]  = '{1'b0, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, DEF, 3, 0};
    vecs[6]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, STL, 3, 0};
    vecs[7]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, BRF, 4, 0};
    vecs[8]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, DEF, 4, 1};
    vecs[9]  = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, STL, 4, 1};
    vecs[10] = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, STL, 5, 1};
    vecs[11] = '{1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, STL, 6, 1};
    vecs[12] = '{1'b0, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, DEF, 0, 0};
    vecs[13] = '{1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, BRF, 0, 0};
    vecs[14] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, DEF, 0, 1};

    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br);
      @(negedge clk);
      check($sformatf("l3_outs[%0d]", i), int'({pw3, iw3, iff3, ief3, emf3}), int'(vecs[i].exp_o));
      check($sformatf("l3_stall_count[%0d]", i), int'(sc3), cexp(vecs[i].exp_s));
      check($sformatf("l3_flush_count[%0d]", i), int'(fc3), cexp(vecs[i].exp_f));
      next_cycle();
    end

    // LOAD_LAT=1: single-cycle stall, then back-to-back hazard
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 5'd2, 5'd5, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    check("l1_hz_outs", int'({pw1, iw1, iff1, ief1, emf1}), int'(STL));
    next_cycle();
    drive(1'b0, 5'd2, 5'd5, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("l1_after_outs", int'({pw1, iw1, iff1, ief1, emf1}), int'(DEF));
    check("l1_stall_count", int'(sc1), cexp(1));
    next_cycle();
    drive(1'b0, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    check("l1_b2b_a", int'({pw1, iw1, iff1, ief1, emf1}), int'(STL));
    next_cycle();
    @(negedge clk);
    check("l1_b2b_b", int'({pw1, iw1, iff1, ief1, emf1}), int'(STL));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("l1_b2b_stall_count", int'(sc1), cexp(3));

    // CNT_W=4 saturation: 20 branch pulses
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 15) check("c4_flush_at_15", int'(fc4), cexp(15));
      next_cycle();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("c4_flush_sat", int'(fc4), cexp(15));
    check("c4_stall_zero", int'(sc4), 0);
    check("l1_flush_20", int'(fc1), cexp(20));
    check("c4_idle_outs", int'({pw4, iw4, iff4, ief4, emf4}), int'(DEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_flush_ctrl
`default_nettype wire
